// File: rtl/uart_pkg.sv
// Shared encodings for the uart_fmt block: parity modes, FSM states and the divisor floor.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  // Below this many clocks-per-bit-minus-1 the mid-bit sample point is ill-defined.
  localparam int MIN_DIV = 3;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_t;

  function automatic logic par_on(input logic [1:0] mode);
    case (mode)
      PAR_EVEN, PAR_ODD: return 1'b1;
      PAR_NONE:          return 1'b0;
      default:           return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable down-counter holding at zero; flag is "expired" for bit timing,
// or "still running" in the STRETCH variant used for the activity LEDs.
module uart_bit_timer #(
  parameter int W       = 16,
  parameter bit STRETCH = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         flag
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             cnt <= '0;
    else if (load)       cnt <= load_val;
    else if (cnt != '0)  cnt <= cnt - W'(1);
  end

  assign flag = STRETCH ? (cnt != '0) : (cnt == '0);

endmodule

// File: rtl/uart_fmt.sv
// Full-duplex UART, 5..9 data bits, optional parity, 1/2 stop bits, runtime divisor.
// TX accepts one byte when idle (tx_ready); RX reports each frame as a one-cycle rx_valid pulse.
module uart_fmt
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 3,
  parameter int LED_W       = 17
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic                 tx,
  input  logic [DIV_W-1:0]     cfg_div,
  input  logic [1:0]           cfg_parity,
  input  logic                 cfg_stop2,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_break,
  output logic                 is_transmitting,
  output logic                 is_receiving
);

  localparam int IDX_W = $clog2(DATA_BITS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  logic [DIV_W-1:0] d_eff;
  assign d_eff = (cfg_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : cfg_div;

  // ---------------- TX ----------------
  tx_state_t            tx_state, tx_state_n;
  logic [DATA_BITS-1:0] tx_sh, tx_sh_n;
  logic [IDX_W-1:0]     tx_idx, tx_idx_n;
  logic [DIV_W-1:0]     tx_div, tx_div_n, tx_tmr_val;
  logic                 tx_pbit, tx_pbit_n, tx_par_en, tx_par_en_n;
  logic                 tx_stop2, tx_stop2_n, tx_second, tx_second_n;
  logic                 tx_tmr_load, tx_zero, tx_go, tx_n;

  assign tx_ready = (tx_state == TX_IDLE);
  assign tx_go    = tx_valid && tx_ready;

  always_comb begin
    tx_state_n  = tx_state;
    tx_sh_n     = tx_sh;
    tx_idx_n    = tx_idx;
    tx_div_n    = tx_div;
    tx_pbit_n   = tx_pbit;
    tx_par_en_n = tx_par_en;
    tx_stop2_n  = tx_stop2;
    tx_second_n = tx_second;
    tx_tmr_load = 1'b0;
    tx_tmr_val  = tx_div;
    case (tx_state)
      TX_IDLE: if (tx_valid) begin
        tx_state_n  = TX_START;
        tx_sh_n     = tx_data;
        tx_pbit_n   = (^tx_data) ^ (cfg_parity == PAR_ODD);
        tx_par_en_n = par_on(cfg_parity);
        tx_stop2_n  = cfg_stop2;
        tx_div_n    = d_eff;
        tx_tmr_load = 1'b1;
        tx_tmr_val  = d_eff;
      end
      TX_START: if (tx_zero) begin
        tx_state_n  = TX_DATA;
        tx_idx_n    = '0;
        tx_tmr_load = 1'b1;
      end
      TX_DATA: if (tx_zero) begin
        tx_sh_n     = tx_sh >> 1;
        tx_idx_n    = tx_idx + IDX_W'(1);
        tx_tmr_load = 1'b1;
        tx_second_n = 1'b0;
        if (tx_idx == LAST_IDX) tx_state_n = tx_par_en ? TX_PARITY : TX_STOP;
      end
      TX_PARITY: if (tx_zero) begin
        tx_state_n  = TX_STOP;
        tx_tmr_load = 1'b1;
      end
      TX_STOP: if (tx_zero) begin
        if (tx_stop2 && !tx_second) begin
          tx_second_n = 1'b1;
          tx_tmr_load = 1'b1;
        end else begin
          tx_state_n = TX_IDLE;
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
    // The line level is registered from next-state values so tx stays glitch-free.
    case (tx_state_n)
      TX_START:  tx_n = 1'b0;
      TX_DATA:   tx_n = tx_sh_n[0];
      TX_PARITY: tx_n = tx_pbit_n;
      default:   tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state  <= TX_IDLE;
      tx_sh     <= '0;
      tx_idx    <= '0;
      tx_div    <= DIV_W'(DEFAULT_DIV);
      tx_pbit   <= 1'b0;
      tx_par_en <= 1'b0;
      tx_stop2  <= 1'b0;
      tx_second <= 1'b0;
      tx        <= 1'b1;
    end else begin
      tx_state  <= tx_state_n;
      tx_sh     <= tx_sh_n;
      tx_idx    <= tx_idx_n;
      tx_div    <= tx_div_n;
      tx_pbit   <= tx_pbit_n;
      tx_par_en <= tx_par_en_n;
      tx_stop2  <= tx_stop2_n;
      tx_second <= tx_second_n;
      tx        <= tx_n;
    end
  end

  uart_bit_timer #(.W(DIV_W)) u_tx_tmr (
    .clk(clk), .rst(rst), .load(tx_tmr_load), .load_val(tx_tmr_val), .flag(tx_zero)
  );
  uart_bit_timer #(.W(LED_W), .STRETCH(1'b1)) u_tx_led (
    .clk(clk), .rst(rst), .load(tx_go), .load_val({LED_W{1'b1}}), .flag(is_transmitting)
  );

  // ---------------- RX ----------------
  logic                 rx_meta, rx_s;
  rx_state_t            rx_state, rx_state_n;
  logic [DATA_BITS-1:0] rx_sh, rx_sh_n, rx_data_n;
  logic [IDX_W-1:0]     rx_idx, rx_idx_n;
  logic [DIV_W-1:0]     rx_div, rx_div_n, rx_tmr_val;
  logic                 rx_pbit, rx_pbit_n, rx_par_en, rx_par_en_n, rx_odd, rx_odd_n;
  logic                 rx_valid_n, ferr_n, perr_n, brk_n;
  logic                 rx_tmr_load, rx_zero, rx_go;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_comb begin
    rx_state_n  = rx_state;
    rx_sh_n     = rx_sh;
    rx_idx_n    = rx_idx;
    rx_div_n    = rx_div;
    rx_pbit_n   = rx_pbit;
    rx_par_en_n = rx_par_en;
    rx_odd_n    = rx_odd;
    rx_data_n   = rx_data;
    rx_valid_n  = 1'b0;
    ferr_n      = rx_frame_err;
    perr_n      = rx_parity_err;
    brk_n       = rx_break;
    rx_go       = 1'b0;
    rx_tmr_load = 1'b0;
    rx_tmr_val  = rx_div;
    case (rx_state)
      RX_IDLE: if (!rx_s) begin
        rx_go       = 1'b1;
        rx_state_n  = RX_START;
        rx_div_n    = d_eff;
        rx_par_en_n = par_on(cfg_parity);
        rx_odd_n    = (cfg_parity == PAR_ODD);
        rx_tmr_load = 1'b1;
        rx_tmr_val  = d_eff >> 1;   // half a bit: later samples land mid-bit
      end
      RX_START: if (rx_zero) begin
        if (rx_s) begin
          rx_state_n = RX_IDLE;
        end else begin
          rx_state_n  = RX_DATA;
          rx_idx_n    = '0;
          rx_tmr_load = 1'b1;
        end
      end
      RX_DATA: if (rx_zero) begin
        rx_sh_n     = {rx_s, rx_sh[DATA_BITS-1:1]};
        rx_idx_n    = rx_idx + IDX_W'(1);
        rx_tmr_load = 1'b1;
        if (rx_idx == LAST_IDX) rx_state_n = rx_par_en ? RX_PARITY : RX_STOP;
      end
      RX_PARITY: if (rx_zero) begin
        rx_pbit_n   = rx_s;
        rx_tmr_load = 1'b1;
        rx_state_n  = RX_STOP;
      end
      RX_STOP: if (rx_zero) begin
        rx_valid_n = 1'b1;
        rx_data_n  = rx_sh;
        ferr_n     = !rx_s;
        perr_n     = rx_par_en && (((^rx_sh) ^ rx_pbit) != rx_odd);
        brk_n      = !rx_s && (rx_sh == '0) && !(rx_par_en && rx_pbit);
        rx_state_n = rx_s ? RX_IDLE : RX_WAIT_HIGH;
      end
      RX_WAIT_HIGH: if (rx_s) rx_state_n = RX_IDLE;
      default: rx_state_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state      <= RX_IDLE;
      rx_sh         <= '0;
      rx_idx        <= '0;
      rx_div        <= DIV_W'(DEFAULT_DIV);
      rx_pbit       <= 1'b0;
      rx_par_en     <= 1'b0;
      rx_odd        <= 1'b0;
      rx_valid      <= 1'b0;
      rx_data       <= '0;
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_break      <= 1'b0;
    end else begin
      rx_state      <= rx_state_n;
      rx_sh         <= rx_sh_n;
      rx_idx        <= rx_idx_n;
      rx_div        <= rx_div_n;
      rx_pbit       <= rx_pbit_n;
      rx_par_en     <= rx_par_en_n;
      rx_odd        <= rx_odd_n;
      rx_valid      <= rx_valid_n;
      rx_data       <= rx_data_n;
      rx_frame_err  <= ferr_n;
      rx_parity_err <= perr_n;
      rx_break      <= brk_n;
    end
  end

  uart_bit_timer #(.W(DIV_W)) u_rx_tmr (
    .clk(clk), .rst(rst), .load(rx_tmr_load), .load_val(rx_tmr_val), .flag(rx_zero)
  );
  uart_bit_timer #(.W(LED_W), .STRETCH(1'b1)) u_rx_led (
    .clk(clk), .rst(rst), .load(rx_go), .load_val({LED_W{1'b1}}), .flag(is_receiving)
  );

endmodule

// File: tb/tb_uart_fmt.sv
// Scoreboarded bench for uart_fmt: a wire-level TX reference and a frame-level RX reference.
module tb_uart_fmt;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tx, tx_ready, rx_valid, rx_frame_err, rx_parity_err, rx_break;
  logic        is_transmitting, is_receiving;
  logic [15:0] cfg_div = 16'd3;
  logic [1:0]  cfg_parity = 2'd0;
  logic        cfg_stop2 = 1'b0;
  logic        tx_valid = 1'b0;
  logic [7:0]  tx_data = 8'h00;
  logic [7:0]  rx_data;
  logic        rx_drv = 1'b1;
  logic        rx_pin;
  bit          loop_en = 1'b1;
  bit          tx_mon_off = 1'b0;

  typedef struct { logic [7:0] data; int d; logic [1:0] par; logic stop2; } txf_t;
  typedef struct { logic [7:0] data; logic perr; logic ferr; logic brk; } rxe_t;

  txf_t txq[$];
  rxe_t rxq[$];
  int checks = 0, failures = 0, rx_pushed = 0, rx_seen = 0;

  always #5 clk = ~clk;
  assign rx_pin = loop_en ? tx : rx_drv;

  uart_fmt dut (
    .clk(clk), .rst(rst), .rx(rx_pin), .tx(tx),
    .cfg_div(cfg_div), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_frame_err(rx_frame_err),
    .rx_parity_err(rx_parity_err), .rx_break(rx_break),
    .is_transmitting(is_transmitting), .is_receiving(is_receiving)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int ones8(input logic [7:0] v);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic int eff_div(input int c);
    return (c < 3) ? 3 : c;
  endfunction

  // Even mode: total count of ones incl. parity is even. Odd mode: it is odd.
  function automatic bit par_bit(input logic [7:0] v, input logic [1:0] pm);
    if (pm == 2'd2) return (ones8(v) % 2) == 0;
    return (ones8(v) % 2) == 1;
  endfunction

  function automatic bit par_used(input logic [1:0] pm);
    return (pm == 2'd1) || (pm == 2'd2);
  endfunction

  task automatic tx_send(input logic [7:0] d);
    txf_t f;
    int   n;
    f.data = d; f.d = eff_div(int'(cfg_div)); f.par = cfg_parity; f.stop2 = cfg_stop2;
    txq.push_back(f);
    if (loop_en) begin
      rxq.push_back(rxe_t'{data: d, perr: 1'b0, ferr: 1'b0, brk: 1'b0});
      rx_pushed++;
    end
    tx_data = d;
    tx_valid = 1'b1;
    n = 0;
    while (tx_ready !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (tx_ready !== 1'b1) begin
      chk("tx_ready_timeout", 0, 1);
      tx_valid = 1'b0;
      return;
    end
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data = 8'($urandom);
    chk("tx_start_low", tx, 0);
  endtask

  task automatic rx_serial(input logic [7:0] d, input logic [1:0] pm, input bit flip, input int dd);
    bit b[$];
    b.push_back(1'b0);
    for (int i = 0; i < 8; i++) b.push_back(d[i]);
    if (par_used(pm)) b.push_back(par_bit(d, pm) ^ flip);
    b.push_back(1'b1);
    rxq.push_back(rxe_t'{data: d, perr: flip && par_used(pm), ferr: 1'b0, brk: 1'b0});
    rx_pushed++;
    foreach (b[i]) begin
      rx_drv = b[i];
      repeat (dd + 1) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    while ((txq.size() != 0 || rxq.size() != 0 || tx_ready !== 1'b1) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) chk("drain_timeout", 1, 0);
    repeat (30) @(negedge clk);
  endtask

  // TX monitor: every falling edge from idle must match the next queued frame bit-for-bit.
  initial begin : tx_mon
    logic prev;
    txf_t f;
    bit   bits[$];
    bit   bad;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b1;
      end else begin
        if (prev && !tx) begin
          if (txq.size() == 0) begin
            if (!tx_mon_off) chk("tx_unexpected_start", 1, 0);
          end else begin
            f = txq.pop_front();
            bits.delete();
            bits.push_back(1'b0);
            for (int i = 0; i < 8; i++) bits.push_back(f.data[i]);
            if (par_used(f.par)) bits.push_back(par_bit(f.data, f.par));
            bits.push_back(1'b1);
            if (f.stop2) bits.push_back(1'b1);
            bad = 1'b0;
            for (int b = 0; b < bits.size(); b++) begin
              for (int c = 0; c <= f.d; c++) begin
                if (b != 0 || c != 0) @(negedge clk);
                if (tx !== bits[b] || tx_ready !== 1'b0) bad = 1'b1;
              end
            end
            chk($sformatf("tx_wave data=%02h d=%0d", f.data, f.d), bad, 0);
            @(negedge clk);
            chk("tx_ready_rise", tx_ready, 1);
          end
        end
        prev = tx;
      end
    end
  end

  // RX monitor: each rx_valid pulse is matched against the next expected frame.
  initial begin : rx_mon
    rxe_t e;
    forever begin
      @(negedge clk);
      if (rx_valid === 1'b1) begin
        rx_seen++;
        if (rxq.size() == 0) begin
          chk($sformatf("rx_unexpected data=%02h", rx_data), 1, 0);
        end else begin
          e = rxq.pop_front();
          chk("rx_data", rx_data, e.data);
          chk("rx_flags {perr,ferr,brk}", {rx_parity_err, rx_frame_err, rx_break},
              {e.perr, e.ferr, e.brk});
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "time limit");
  end

  initial begin : stim
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_flags", {rx_frame_err, rx_parity_err, rx_break}, 0);
    chk("rst_activity", {is_transmitting, is_receiving}, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // 8N1 at 4 clocks/bit, looped back.
    tx_send(8'h55);
    drain();
    chk("is_transmitting", is_transmitting, 1);
    chk("is_receiving", is_receiving, 1);

    // Even parity, two stop bits, back-to-back.
    cfg_parity = 2'd1;
    cfg_stop2  = 1'b1;
    tx_send(8'h00); repeat (4) @(negedge clk);
    tx_send(8'h07); repeat (4) @(negedge clk);
    tx_send(8'hFF);
    drain();

    // Randomised formats, including divisors below the floor and the reserved parity code.
    for (int k = 0; k < 16; k++) begin
      cfg_div    = 16'($urandom_range(0, 6));
      cfg_parity = 2'($urandom_range(0, 3));
      cfg_stop2  = 1'($urandom_range(0, 1));
      tx_send(8'($urandom));
      repeat (4) @(negedge clk);
    end
    drain();

    // Bench-driven RX: odd parity with the parity bit inverted.
    loop_en    = 1'b0;
    cfg_div    = 16'd3;
    cfg_parity = 2'd2;
    cfg_stop2  = 1'b0;
    rx_serial(8'hA5, 2'd2, 1'b1, 3);
    drain();

    // Break: line low for 20 bit periods, then a clean frame.
    cfg_parity = 2'd0;
    rxq.push_back(rxe_t'{data: 8'h00, perr: 1'b0, ferr: 1'b1, brk: 1'b1});
    rx_pushed++;
    rx_drv = 1'b0;
    repeat (80) @(negedge clk);
    rx_drv = 1'b1;
    repeat (20) @(negedge clk);
    rx_serial(8'h3C, 2'd0, 1'b0, 3);
    drain();

    // One-cycle glitch on idle line.
    rx_drv = 1'b0;
    @(negedge clk);
    rx_drv = 1'b1;
    repeat (40) @(negedge clk);

    // Divisor change mid-frame only affects the following frame.
    loop_en = 1'b1;
    cfg_div = 16'd3;
    tx_send(8'hC3);
    repeat (10) @(negedge clk);
    cfg_div = 16'd7;
    tx_send(8'h5A);
    drain();

    // Reset in the middle of a TX and an RX frame.
    tx_mon_off = 1'b1;
    loop_en    = 1'b0;
    tx_data    = 8'($urandom);
    tx_valid   = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    rx_drv   = 1'b0;
    repeat (15) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_tx", tx, 1);
    chk("midrst_tx_ready", tx_ready, 1);
    chk("midrst_rx_valid", rx_valid, 0);
    chk("midrst_activity", {is_transmitting, is_receiving}, 0);
    rx_drv = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    tx_mon_off = 1'b0;
    loop_en    = 1'b1;
    tx_send(8'($urandom));
    drain();

    chk("txq_empty", txq.size(), 0);
    chk("rxq_empty", rxq.size(), 0);
    chk("rx_count", rx_seen, rx_pushed);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
